dht11_reader: RTL
=================

Name: dht11_reader

Overview:
- Single-wire DHT11 transaction engine beneath the sensor-connection block; turns a one-cycle start request into a full 40-bit read on the tri-state `transmission_line`.
- Presents humidity and temperature bytes plus a checksum verdict for the response formatter that feeds `uart_tx`.
- Owns all bus timing: host start pulse, sensor response check, bit decoding and timeouts.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; sets the 1 us tick prescaler (CLK_FREQ_HZ/1000000 cycles per tick).
- START_LOW_US, 18000, host start-pulse length in us.
- BIT_THRESH_US, 50, high-pulse length at or above which a data bit decodes as 1.
- TIMEOUT_US, 200, maximum duration of any single wait phase before error.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- transmission_line  inout  1  DHT11 data wire; driven 0 or high-Z, never driven 1.
- busy  out  1  high from the accepted start until DONE or ERROR is left.
- done  out  1  one-cycle pulse when a frame ends, valid or not.
- error  out  1  sticky; set on timeout or checksum failure; cleared by the next accepted start.
- humidity_int  out  8  byte 0 of the frame.
- humidity_dec  out  8  byte 1 of the frame.
- temperature_int  out  8  byte 2 of the frame.
- temperature_dec  out  8  byte 3 of the frame.
- checksum_ok  out  1  byte4 == (b0+b1+b2+b3) mod 256; valid when done pulses.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, line released (high-Z), busy=0, done=0, error=0, checksum_ok=0, all data bytes=0x00, counters=0.
- A reset mid-transaction releases the line immediately and aborts the read; no done pulse is generated.
- Line input: 2-flop synchroniser before any use, which adds 2 cycles of latency. Edge detection uses the synchronised value.
- Time base: the prescaler produces a 1-cycle tick every 1 us. A 16-bit us_cnt clears on every state entry and saturates at 0xFFFF.
- State machine:
  - IDLE: line released. start=1 -> START_LOW; set busy, clear error and checksum_ok.
  - START_LOW: drive 0. When us_cnt==START_LOW_US -> RELEASE.
  - RELEASE: line released. Sync line low -> RESP_LOW. us_cnt==TIMEOUT_US -> ERROR.
  - RESP_LOW: sensor drives ~80 us low. Rising edge -> RESP_HIGH. Timeout -> ERROR.
  - RESP_HIGH: ~80 us high. Falling edge -> BIT_LOW with bit_idx=0. Timeout -> ERROR.
  - BIT_LOW: ~50 us low. Rising edge -> BIT_HIGH. Timeout -> ERROR.
  - BIT_HIGH: on falling edge, shift in bit = (us_cnt >= BIT_THRESH_US) into a 40-bit register, MSB first.
    - If bit_idx==39 -> CHECK; otherwise bit_idx+1 -> BIT_LOW.
    - Timeout -> ERROR.
  - CHECK (1 cycle): copy shift-register bytes 0..3 to the outputs and compute checksum_ok; set error=!checksum_ok -> DONE.
  - DONE (1 cycle): done=1; then busy=0 and -> IDLE.
  - ERROR (1 cycle): error=1, done=1, data outputs keep their previous values; then busy=0 and -> IDLE.
- Ignored inputs: start while busy is ignored. A start in the same cycle as DONE or ERROR is also ignored; it is only accepted once IDLE is reached.
- The final bit is completed by the sensor's falling edge at the start of its 50 us end-of-frame low. The line then returns high by pull-up; no wait on that is required.
- Checksum arithmetic is an 8-bit sum with carries discarded.

Test Plan:
- Normal frame: sensor model sends 0x37,0x00,0x19,0x00,0x50 -> done pulses once; outputs 0x37/0x00/0x19/0x00; checksum_ok=1, error=0; line held low 18000+/-1 us before release.
- Bad checksum: frame 0x37,0x00,0x19,0x00,0x51 -> done=1, checksum_ok=0, error=1; data bytes still updated to 0x37/0x00/0x19/0x00.
- No sensor: line stays high after release -> ERROR 200 us after release; done=1, error=1; data bytes unchanged from the previous frame.
- Bit threshold: high pulses of 26 us and 70 us decode as 0 and 1; a 49 us pulse decodes as 0, a 50 us pulse as 1 (frame 0xAA,0x55,0x00,0xFF,0xFE -> checksum_ok=1).
- Mid-frame abort: assert reset after bit 20 -> line high-Z within the same cycle; all outputs 0. A new start after reset completes a normal frame.
- Start while busy: pulse start at bit 10 -> ignored; exactly one done pulse; next start after IDLE is accepted and clears the sticky error.

Source files
------------

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: start pulse, response check, 40-bit decode, checksum verdict.
// Latency: START_LOW_US + sensor frame (~4-5 ms) from accepted start to the done pulse.
// No backpressure: start is only accepted in IDLE, and results are held until the next frame.
module dht11_reader #(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int START_LOW_US  = 18000,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    inout  wire        transmission_line,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] humidity_int,
    output logic [7:0] humidity_dec,
    output logic [7:0] temperature_int,
    output logic [7:0] temperature_dec,
    output logic       checksum_ok
);

    localparam int TICK_DIV = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;
    localparam int PRE_W    = $clog2(TICK_DIV + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_START_LOW, ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH,
        ST_BIT_LOW, ST_BIT_HIGH, ST_CHECK, ST_DONE, ST_ERROR
    } stateT;

    stateT             state;
    logic              driveLow;
    logic              lineMeta, lineSync, linePrev;
    logic              lineRise, lineFall;
    logic [PRE_W-1:0]  preCnt;
    logic              tick;
    logic [15:0]       usCnt;
    logic              timeUp;
    logic [16:0]       highUs;
    logic              bitVal;
    logic [39:0]       shiftReg;
    logic [5:0]        bitIdx;
    logic [7:0]        byteSum;
    logic              sumOk;

    // The wire is only ever pulled low; a high level comes from the pull-up.
    assign transmission_line = driveLow ? 1'b0 : 1'bz;

    assign tick     = (preCnt == PRE_W'(TICK_DIV - 1));
    assign lineRise = lineSync & ~linePrev;
    assign lineFall = ~lineSync & linePrev;
    assign timeUp   = (usCnt == 16'(TIMEOUT_US));

    // Count the tick landing on this very edge too, so a pulse of N whole
    // microseconds measures exactly N regardless of prescaler phase.
    assign highUs = {1'b0, usCnt} + {16'd0, tick};
    assign bitVal = (highUs >= 17'(BIT_THRESH_US));

    assign byteSum = shiftReg[39:32] + shiftReg[31:24] + shiftReg[23:16] + shiftReg[15:8];
    assign sumOk   = (byteSum == shiftReg[7:0]);

    // Two-flop synchroniser plus one delayed copy for edge detection; idle level is high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lineMeta <= 1'b1;
            lineSync <= 1'b1;
            linePrev <= 1'b1;
        end else begin
            lineMeta <= transmission_line;
            lineSync <= lineMeta;
            linePrev <= lineSync;
        end
    end

    // Free-running 1 us tick prescaler.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            preCnt <= '0;
        end else begin
            preCnt <= tick ? '0 : preCnt + PRE_W'(1);
        end
    end

    // Transaction FSM; usCnt restarts on every state entry and saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            driveLow        <= 1'b0;
            usCnt           <= '0;
            shiftReg        <= '0;
            bitIdx          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            checksum_ok     <= 1'b0;
            humidity_int    <= '0;
            humidity_dec    <= '0;
            temperature_int <= '0;
            temperature_dec <= '0;
        end else begin
            done <= 1'b0;
            if (tick && usCnt != 16'hFFFF) begin
                usCnt <= usCnt + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_START_LOW;
                        usCnt       <= '0;
                        driveLow    <= 1'b1;
                        busy        <= 1'b1;
                        error       <= 1'b0;
                        checksum_ok <= 1'b0;
                    end
                end
                ST_START_LOW: begin
                    if (usCnt == 16'(START_LOW_US)) begin
                        state    <= ST_RELEASE;
                        usCnt    <= '0;
                        driveLow <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    // Our own low still echoes through the synchroniser right after
                    // release, so wait for a fresh falling edge from the sensor.
                    if (lineFall) begin
                        state <= ST_RESP_LOW;
                        usCnt <= '0;
                    end else if (timeUp) begin
                        state <= ST_ERROR;
                        usCnt <= '0;
                        error <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ST_RESP_LOW: begin
                    if (lineRise) begin
                        state <= ST_RESP_HIGH;
                        usCnt <= '0;
                    end else if (timeUp) begin
                        state <= ST_ERROR;
                        usCnt <= '0;
                        error <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ST_RESP_HIGH: begin
                    if (lineFall) begin
                        state  <= ST_BIT_LOW;
                        usCnt  <= '0;
                        bitIdx <= '0;
                    end else if (timeUp) begin
                        state <= ST_ERROR;
                        usCnt <= '0;
                        error <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ST_BIT_LOW: begin
                    if (lineRise) begin
                        state <= ST_BIT_HIGH;
                        usCnt <= '0;
                    end else if (timeUp) begin
                        state <= ST_ERROR;
                        usCnt <= '0;
                        error <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ST_BIT_HIGH: begin
                    if (lineFall) begin
                        shiftReg <= {shiftReg[38:0], bitVal};
                        usCnt    <= '0;
                        if (bitIdx == 6'd39) begin
                            state <= ST_CHECK;
                        end else begin
                            state  <= ST_BIT_LOW;
                            bitIdx <= bitIdx + 6'd1;
                        end
                    end else if (timeUp) begin
                        state <= ST_ERROR;
                        usCnt <= '0;
                        error <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    humidity_int    <= shiftReg[39:32];
                    humidity_dec    <= shiftReg[31:24];
                    temperature_int <= shiftReg[23:16];
                    temperature_dec <= shiftReg[15:8];
                    checksum_ok     <= sumOk;
                    error           <= ~sumOk;
                    done            <= 1'b1;
                    state           <= ST_DONE;
                    usCnt           <= '0;
                end
                ST_DONE, ST_ERROR: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    usCnt <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    driveLow <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
